// File: rtl/tcm4671_spi_responder_if.sv
// Pin-level SPI bus plus the write-notification and frame-error outputs of the
// TCM4671-style register responder.
`timescale 1ns/1ps
interface tcm4671_spi_responder_if;
    logic        SCK;
    logic        MOSI;
    logic        nSCS;
    logic        MISO;
    logic        MISO_oe;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;

    modport master (output SCK, MOSI, nSCS,
                    input  MISO, MISO_oe, wr_valid, wr_addr, wr_data, frame_err);
    modport slave  (input  SCK, MOSI, nSCS,
                    output MISO, MISO_oe, wr_valid, wr_addr, wr_data, frame_err);
endinterface

// File: rtl/tcm4671_spi_responder.sv
// SPI mode-3 register responder: 40-bit datagrams (R/W, 7-bit address, 32-bit data)
// oversampled on clk, with a read-only chip ID at address 0.
`timescale 1ns/1ps
module tcm4671_spi_responder #(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] CHIP_ID  = 32'h34363731
) (
    input  logic                          clk,
    input  logic                          reset,
    tcm4671_spi_responder_if.slave        spi
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, TAIL = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sck_sync_q, ncs_sync_q, mosi_sync_q;
    logic        sck_prev_q, ncs_prev_q;
    logic [1:0]  flush_q;
    logic        armed_q, armed_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [38:0] rx_q, rx_d;
    logic [31:0] tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        oe_q;
    logic        wr_valid_q, wr_valid_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] regs_q [1:NUM_REGS-1];

    logic        sck_s, ncs_s, mosi_s;
    logic        sck_rise_s, sck_fall_s, ncs_fall_s;
    logic [6:0]  rd_addr_s, wr_addr_s;
    logic [31:0] rd_val_s, wr_data_s;
    logic        commit_s;

    assign sck_s      = sck_sync_q[1];
    assign ncs_s      = ncs_sync_q[1];
    assign mosi_s     = mosi_sync_q[1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    // A frame only starts once nSCS has been seen high after reset, so a frame
    // already in flight at reset release is ignored.
    assign ncs_fall_s = armed_q & ~ncs_s & ncs_prev_q;
    assign rd_addr_s  = {rx_q[5:0], mosi_s};
    assign wr_addr_s  = rx_q[37:31];
    assign wr_data_s  = {rx_q[30:0], mosi_s};

    // Two-flop synchronizers and one-cycle-delayed copies for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= 2'b11;
            ncs_sync_q  <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b1;
            ncs_prev_q  <= 1'b1;
            flush_q     <= 2'b00;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi.SCK};
            ncs_sync_q  <= {ncs_sync_q[0], spi.nSCS};
            mosi_sync_q <= {mosi_sync_q[0], spi.MOSI};
            sck_prev_q  <= sck_s;
            ncs_prev_q  <= ncs_s;
            flush_q     <= {flush_q[0], 1'b1};
        end
    end

    // Read-value mux: chip ID, in-range storage, or zero.
    always_comb begin
        rd_val_s = 32'd0;
        if (rd_addr_s == 7'd0) begin
            rd_val_s = CHIP_ID;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                rd_val_s = (rd_addr_s == 7'(i)) ? regs_q[i] : rd_val_s;
            end
        end
    end

    // Frame FSM next state, shifters and output next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        commit_s    = 1'b0;
        armed_d     = armed_q | (flush_q[1] & ncs_s);
        if (ncs_s) begin
            state_d     = IDLE;
            cnt_d       = 6'd0;
            tx_d        = 32'd0;
            miso_d      = 1'b0;
            frame_err_d = (state_q == ADDR) || (state_q == DATA);
        end else begin
            case (state_q)
                IDLE: begin
                    if (ncs_fall_s) begin
                        state_d = ADDR;
                        cnt_d   = 6'd0;
                        tx_d    = 32'd0;
                        miso_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR: begin
                    if (sck_rise_s) begin
                        rx_d  = {rx_q[37:0], mosi_s};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd7) begin
                            state_d = DATA;
                            tx_d    = rx_q[6] ? 32'd0 : rd_val_s;
                        end else begin
                            state_d = ADDR;
                        end
                    end else begin
                        state_d = ADDR;
                    end
                end
                DATA: begin
                    if (sck_fall_s) begin
                        miso_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b0};
                    end else if (sck_rise_s) begin
                        rx_d  = {rx_q[37:0], mosi_s};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd39) begin
                            state_d    = TAIL;
                            commit_s   = rx_q[38];
                            wr_valid_d = rx_q[38];
                            wr_addr_d  = rx_q[38] ? wr_addr_s : wr_addr_q;
                            wr_data_d  = rx_q[38] ? wr_data_s : wr_data_q;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                TAIL: begin
                    state_d = TAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            cnt_q       <= 6'd0;
            rx_q        <= 39'd0;
            tx_q        <= 32'd0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 32'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            oe_q        <= ~ncs_s;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage registers 1..NUM_REGS-1; address 0 and out-of-range writes land nowhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit_s && (wr_addr_s == 7'(i))) begin
                    regs_q[i] <= wr_data_s;
                end
            end
        end
    end

    assign spi.MISO      = miso_q;
    assign spi.MISO_oe   = oe_q;
    assign spi.wr_valid  = wr_valid_q;
    assign spi.wr_addr   = wr_addr_q;
    assign spi.wr_data   = wr_data_q;
    assign spi.frame_err = frame_err_q;
endmodule

// File: tb/tb_tcm4671_spi_responder.sv
// Directed bench for the SPI responder: mode-3 frames driven at 10 clk per SCK
// period, with pulse counters on wr_valid and frame_err.
`timescale 1ns/1ps
module tb_tcm4671_spi_responder;
    localparam int          HALF    = 50;
    localparam logic [31:0] CHIP_ID = 32'h34363731;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   wr_cnt;
    int   ferr_cnt;
    logic [39:0] rx;
    logic        oe_mid;

    tcm4671_spi_responder_if spi ();

    tcm4671_spi_responder #(.NUM_REGS(16), .CHIP_ID(CHIP_ID)) dut (
        .clk   (clk),
        .reset (reset),
        .spi   (spi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count single-cycle pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (spi.wr_valid === 1'b1) wr_cnt = wr_cnt + 1;
        if (spi.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [39:0] word, input int nbits, output logic [39:0] got);
        got = 40'd0;
        for (int j = 0; j < nbits; j++) begin
            spi.SCK  = 1'b0;
            spi.MOSI = word[39-j];
            #(HALF);
            got[39-j] = spi.MISO;
            spi.SCK   = 1'b1;
            #(HALF);
        end
    endtask

    task automatic frame(input logic [39:0] word, input int nbits, input int gap,
                         output logic [39:0] got);
        spi.nSCS = 1'b0;
        #40;
        spi_bits(word, nbits, got);
        oe_mid = spi.MISO_oe;
        #(HALF);
        spi.nSCS = 1'b1;
        #(gap);
    endtask

    initial begin
        checks = 0; failures = 0; wr_cnt = 0; ferr_cnt = 0;
        spi.SCK = 1'b1; spi.MOSI = 1'b0; spi.nSCS = 1'b1;
        reset = 1'b0;
        #30;
        check("rst_miso",      64'(spi.MISO),      64'd0);
        check("rst_oe",        64'(spi.MISO_oe),   64'd0);
        check("rst_wr_valid",  64'(spi.wr_valid),  64'd0);
        check("rst_frame_err", 64'(spi.frame_err), 64'd0);
        check("rst_wr_addr",   64'(spi.wr_addr),   64'd0);
        check("rst_wr_data",   64'(spi.wr_data),   64'd0);
        @(negedge clk);
        reset = 1'b1;
        #100;

        // Chip ID read
        frame(40'h00_00000000, 40, 100, rx);
        check("id_hdr",    64'(rx[39:32]), 64'd0);
        check("id_data",   64'(rx[31:0]),  64'(CHIP_ID));
        check("oe_in",     64'(oe_mid),    64'd1);
        check("oe_out",    64'(spi.MISO_oe), 64'd0);
        check("read_nowr", 64'(wr_cnt),    64'd0);

        // Write 0x05 then read back
        frame(40'h85_12345678, 40, 100, rx);
        check("w5_cnt",  64'(wr_cnt),      64'd1);
        check("w5_addr", 64'(spi.wr_addr), 64'h05);
        check("w5_data", 64'(spi.wr_data), 64'h12345678);
        frame(40'h05_00000000, 40, 100, rx);
        check("r5_hdr",  64'(rx[39:32]), 64'd0);
        check("r5_data", 64'(rx[31:0]),  64'h12345678);
        check("r5_nowr", 64'(wr_cnt),    64'd1);

        // Out-of-range address 0x7F
        frame(40'hFF_0000000A, 40, 100, rx);
        check("w7f_cnt",  64'(wr_cnt),      64'd2);
        check("w7f_addr", 64'(spi.wr_addr), 64'h7F);
        check("w7f_data", 64'(spi.wr_data), 64'h0A);
        frame(40'h7F_00000000, 40, 100, rx);
        check("r7f_data", 64'(rx[31:0]), 64'd0);

        // Write to address 0 leaves chip ID intact
        frame(40'h80_DEADBEEF, 40, 100, rx);
        check("w0_cnt", 64'(wr_cnt), 64'd3);
        frame(40'h00_00000000, 40, 100, rx);
        check("r0_data", 64'(rx[31:0]), 64'(CHIP_ID));

        // Top storage register and first out-of-range address
        frame(40'h8F_CAFEF00D, 40, 100, rx);
        frame(40'h90_11111111, 40, 100, rx);
        check("w_top_cnt", 64'(wr_cnt), 64'd5);
        frame(40'h0F_00000000, 40, 100, rx);
        check("r0f_data", 64'(rx[31:0]), 64'hCAFEF00D);
        frame(40'h10_00000000, 40, 100, rx);
        check("r10_data", 64'(rx[31:0]), 64'd0);
        check("no_ferr",  64'(ferr_cnt), 64'd0);

        // Short frame aborted after 20 bits
        frame(40'h85_FFFFFFFF, 20, 100, rx);
        check("abort_ferr", 64'(ferr_cnt), 64'd1);
        check("abort_nowr", 64'(wr_cnt),   64'd5);
        frame(40'h05_00000000, 40, 100, rx);
        check("abort_r5",   64'(rx[31:0]), 64'h12345678);

        // Reset after 30 bits, released while the frame keeps clocking
        spi.nSCS = 1'b0;
        #40;
        spi_bits(40'h83_AAAAAAAA, 30, rx);
        @(negedge clk);
        reset = 1'b0;
        #30;
        reset = 1'b1;
        spi_bits(40'h83_AAAAAAAA << 30, 10, rx);
        #(HALF);
        spi.nSCS = 1'b1;
        #100;
        check("rst_mid_nowr",    64'(wr_cnt),      64'd5);
        check("rst_mid_noferr",  64'(ferr_cnt),    64'd1);
        check("rst_mid_wr_addr", 64'(spi.wr_addr), 64'd0);
        frame(40'h03_00000000, 40, 100, rx);
        check("rst_mid_r3", 64'(rx[31:0]), 64'd0);
        frame(40'h05_00000000, 40, 100, rx);
        check("rst_mid_r5", 64'(rx[31:0]), 64'd0);

        // Back-to-back writes with a 4-clk nSCS gap
        frame(40'h81_00000001, 40, 40, rx);
        frame(40'h82_00000002, 40, 100, rx);
        check("b2b_cnt",  64'(wr_cnt),      64'd7);
        check("b2b_addr", 64'(spi.wr_addr), 64'h02);
        frame(40'h01_00000000, 40, 100, rx);
        check("b2b_r1", 64'(rx[31:0]), 64'd1);
        frame(40'h02_00000000, 40, 100, rx);
        check("b2b_r2", 64'(rx[31:0]), 64'd2);
        check("end_ferr", 64'(ferr_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
